// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: one access at a time on a shared memory port,
// round-robin or fixed-priority selection, read response routed back to the owner.
module mem_arbiter #(
    parameter int ADDR_W     = 14,
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [31:0]       m0_wdata,
    input  logic [1:0]        m0_wsize,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [31:0]       m0_rdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [31:0]       m1_wdata,
    input  logic [1:0]        m1_wsize,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [31:0]       m1_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rstrb,
    output logic              mem_wstrb,
    output logic [31:0]       mem_wdata,
    output logic [1:0]        mem_wsize,
    input  logic [31:0]       mem_rdata
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t              state_r, state_next_s;
    logic                last_r;
    logic                owner_r;
    logic                we_r;
    logic [ADDR_W-1:0]   addr_r;
    logic [31:0]         wdata_r;
    logic [1:0]          wsize_r;
    logic                gnt0_r, gnt1_r, rvalid0_r, rvalid1_r, rstrb_r, wstrb_r;
    logic                any_req_s, winner_s;
    logic                sel_we_s;
    logic [ADDR_W-1:0]   sel_addr_s;
    logic [31:0]         sel_wdata_s;
    logic [1:0]          sel_wsize_s;

    assign any_req_s = m0_req | m1_req;

    // Winner selection: on a tie, fixed priority favours port 0, round-robin the port not granted last
    always_comb begin
        winner_s = 1'b0;
        if (m0_req && m1_req) begin
            winner_s = FIXED_PRIO ? 1'b0 : ~last_r;
        end else if (m1_req) begin
            winner_s = 1'b1;
        end else begin
            winner_s = 1'b0;
        end
    end

    // Request fields of the selected port, captured on entry to ISSUE
    always_comb begin
        sel_we_s    = m0_we;
        sel_addr_s  = m0_addr;
        sel_wdata_s = m0_wdata;
        sel_wsize_s = m0_wsize;
        if (winner_s) begin
            sel_we_s    = m1_we;
            sel_addr_s  = m1_addr;
            sel_wdata_s = m1_wdata;
            sel_wsize_s = m1_wsize;
        end else begin
            sel_we_s    = m0_we;
            sel_addr_s  = m0_addr;
            sel_wdata_s = m0_wdata;
            sel_wsize_s = m0_wsize;
        end
    end

    // Next-state logic: writes finish after ISSUE, reads spend one more cycle in RESP
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (any_req_s) state_next_s = ISSUE;
                else           state_next_s = IDLE;
            end
            ISSUE: begin
                if (we_r) state_next_s = IDLE;
                else      state_next_s = RESP;
            end
            RESP:    state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // State, capture registers and registered pulse outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= IDLE;
            last_r    <= 1'b1;
            owner_r   <= 1'b0;
            we_r      <= 1'b0;
            addr_r    <= {ADDR_W{1'b0}};
            wdata_r   <= 32'd0;
            wsize_r   <= 2'd0;
            gnt0_r    <= 1'b0;
            gnt1_r    <= 1'b0;
            rvalid0_r <= 1'b0;
            rvalid1_r <= 1'b0;
            rstrb_r   <= 1'b0;
            wstrb_r   <= 1'b0;
        end else begin
            state_r   <= state_next_s;
            gnt0_r    <= 1'b0;
            gnt1_r    <= 1'b0;
            rvalid0_r <= 1'b0;
            rvalid1_r <= 1'b0;
            rstrb_r   <= 1'b0;
            wstrb_r   <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (any_req_s) begin
                        owner_r <= winner_s;
                        last_r  <= winner_s;
                        we_r    <= sel_we_s;
                        addr_r  <= sel_addr_s;
                        wdata_r <= sel_wdata_s;
                        wsize_r <= sel_wsize_s;
                        gnt0_r  <= ~winner_s;
                        gnt1_r  <= winner_s;
                        rstrb_r <= ~sel_we_s;
                        wstrb_r <= sel_we_s;
                    end else begin
                        owner_r <= owner_r;
                    end
                end
                ISSUE: begin
                    if (!we_r) begin
                        rvalid0_r <= ~owner_r;
                        rvalid1_r <= owner_r;
                    end else begin
                        rvalid0_r <= 1'b0;
                        rvalid1_r <= 1'b0;
                    end
                end
                RESP:    state_r <= state_next_s;
                default: state_r <= IDLE;
            endcase
        end
    end

    // Pulses are masked while reset is high so an aborted access never shows a response
    assign m0_gnt    = gnt0_r    & ~reset;
    assign m1_gnt    = gnt1_r    & ~reset;
    assign m0_rvalid = rvalid0_r & ~reset;
    assign m1_rvalid = rvalid1_r & ~reset;
    assign mem_rstrb = rstrb_r   & ~reset;
    assign mem_wstrb = wstrb_r   & ~reset;
    assign mem_addr  = addr_r;
    assign mem_wdata = wdata_r;
    assign mem_wsize = wsize_r;
    assign m0_rdata  = mem_rdata;
    assign m1_rdata  = mem_rdata;

endmodule
